// File: rtl/gshare_predictor_pkg.sv
// Shared constants for the gshare predictor: counter encodings, default
// geometry and the statistic saturation ceiling.
package gshare_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_state_e;

  localparam int DEFAULT_BHT_BITS  = 8;
  localparam int DEFAULT_HIST_BITS = 4;

  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  // Saturating +1 for the 32-bit statistics.
  function automatic logic [31:0] stat_inc(input logic [31:0] value);
    stat_inc = (value == STAT_MAX) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/gshare_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
  import gshare_predictor_pkg::*;
(
  input  logic [1:0] value,
  input  logic       up,
  output logic [1:0] next_value
);

  always_comb begin
    next_value = value;
    if (up) begin
      if (value != ST) next_value = value + 2'd1;
    end else begin
      if (value != SNT) next_value = value - 2'd1;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: combinational query from fetch, commit-time
// training from the RoB, plus branch and mispredict statistics.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int BHT_BITS  = DEFAULT_BHT_BITS,
  parameter int HIST_BITS = DEFAULT_HIST_BITS
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] if_pc,
  output logic        pred_jump,
  input  logic        rob_valid,
  input  logic [31:0] now_pc,
  input  logic        should_jump,
  input  logic        rob_clear,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
);

  localparam int ENTRIES = 1 << BHT_BITS;

  logic [1:0]           bht [ENTRIES];
  logic [HIST_BITS-1:0] ghr;
  logic [HIST_BITS-1:0] ghr_next;
  logic [BHT_BITS-1:0]  ghr_ext;
  logic [BHT_BITS-1:0]  query_idx;
  logic [BHT_BITS-1:0]  update_idx;
  logic [1:0]           cur_ctr;
  logic [1:0]           next_ctr;
  logic                 do_update;
  logic                 unused_pc_bits;

  assign unused_pc_bits = ^{if_pc[31:BHT_BITS+2], if_pc[1:0],
                            now_pc[31:BHT_BITS+2], now_pc[1:0]};

  // History is zero-extended into the low index bits; this form also
  // covers HIST_BITS == BHT_BITS without a zero-width replication.
  always_comb begin
    ghr_ext = '0;
    ghr_ext[HIST_BITS-1:0] = ghr;
  end

  assign query_idx  = if_pc[BHT_BITS+1:2] ^ ghr_ext;
  assign update_idx = now_pc[BHT_BITS+1:2] ^ ghr_ext;
  assign do_update  = rdy_in & rob_valid;

  // Same-cycle query and update both see registered state; no forwarding.
  assign pred_jump = bht[query_idx][1];
  assign cur_ctr   = bht[update_idx];

  sat_counter2 u_sat_counter2 (
    .value      (cur_ctr),
    .up         (should_jump),
    .next_value (next_ctr)
  );

  generate
    if (HIST_BITS == 1) begin : g_hist_one
      assign ghr_next = should_jump;
    end else begin : g_hist_many
      assign ghr_next = {ghr[HIST_BITS-2:0], should_jump};
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int k = 0; k < ENTRIES; k++) bht[k] <= WNT;
    end else if (do_update) begin
      bht[update_idx] <= next_ctr;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ghr           <= '0;
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (do_update) begin
      ghr           <= ghr_next;
      stat_branches <= stat_inc(stat_branches);
      if (rob_clear) stat_mispred <= stat_inc(stat_mispred);
    end
  end

endmodule
